// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and widths.
package fetch_pkg;

    // FSM states; encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FLUSH = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

    // Default PC / instruction-address width.
    localparam int FETCH_PC_W = 12;

    // Width of the performance counters.
    localparam int PERF_CNT_W = 16;

    // Bubble counter width; holds REDIRECT_BUBBLES-1 for 1..7 bubbles.
    localparam int BUBBLE_CNT_W = 3;

endpackage : fetch_pkg

// File: rtl/sat_counter16.sv
// Saturating event counter with asynchronous active-high reset.
// Increments by one on each enabled edge and sticks at all-ones.
module sat_counter16
    import fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    output logic [PERF_CNT_W-1:0] count_o
);

    logic [PERF_CNT_W-1:0] count_q;
    logic [PERF_CNT_W-1:0] count_d;

    // Next count: advance when enabled unless already saturated.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {PERF_CNT_W{1'b1}})) begin
            count_d = count_q + PERF_CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter16

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the IA-stage PC and issue enable, sequencing boot,
// hazard stall, branch redirect with wrong-path flush, and halt.
// Optional macro FETCH_PERF_EN adds saturating issue/redirect counters;
// without it issue_count and redirect_count are tied to zero.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W             = FETCH_PC_W,
    parameter logic [PC_W-1:0] RESET_PC         = '0,
    parameter int              REDIRECT_BUBBLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_req,
    input  logic                  halt_req,
    input  logic                  redirect_valid,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic [PC_W-1:0]       ia_pc,
    output logic                  ia_en,
    output logic                  flush,
    output logic [1:0]            state,
    output logic [PERF_CNT_W-1:0] issue_count,
    output logic [PERF_CNT_W-1:0] redirect_count
);

    // Loaded on each accepted redirect; FLUSH lasts this value plus one cycle.
    localparam logic [BUBBLE_CNT_W-1:0] BUB_INIT = BUBBLE_CNT_W'(REDIRECT_BUBBLES - 1);

    fetch_state_e            state_q, state_d;
    logic [PC_W-1:0]         pc_q, pc_d;
    logic [BUBBLE_CNT_W-1:0] bub_q, bub_d;

    // Next-state, PC and bubble-counter logic; redirect > halt > stall > issue.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bub_d   = bub_q;
        unique case (state_q)
            FS_BOOT: begin
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    bub_d   = BUB_INIT;
                    state_d = FS_FLUSH;
                end else if (halt_req) begin
                    state_d = FS_HALT;
                end else if (!stall_req) begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            FS_FLUSH: begin
                if (redirect_valid) begin
                    pc_d  = redirect_pc;
                    bub_d = BUB_INIT;
                end else if (bub_q == '0) begin
                    state_d = FS_RUN;
                end else begin
                    bub_d = bub_q - BUBBLE_CNT_W'(1);
                end
            end
            FS_HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    bub_d   = BUB_INIT;
                    state_d = FS_FLUSH;
                end
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    // FSM, PC and bubble-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_BOOT;
            pc_q    <= RESET_PC;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bub_q   <= bub_d;
        end
    end

    // Issue only in RUN with no competing request this cycle.
    assign ia_en = (state_q == FS_RUN) & ~stall_req & ~halt_req & ~redirect_valid;
    assign flush = (state_q == FS_FLUSH);
    assign ia_pc = pc_q;
    assign state = state_q;

`ifdef FETCH_PERF_EN
    // A redirect is taken in every state except BOOT.
    logic redirect_accept;
    assign redirect_accept = redirect_valid & (state_q != FS_BOOT);

    sat_counter16 u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ia_en),
        .count_o (issue_count)
    );

    sat_counter16 u_redirect_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (redirect_accept),
        .count_o (redirect_count)
    );
`else
    assign issue_count    = '0;
    assign redirect_count = '0;
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_fetch_sequencer;

    localparam int BUB = 2;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall_req;
    logic        halt_req;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [11:0] ia_pc;
    logic        ia_en;
    logic        flush;
    logic [1:0]  state;
    logic [15:0] issue_count;
    logic [15:0] redirect_count;

    fetch_sequencer #(
        .PC_W             (12),
        .RESET_PC         (12'h000),
        .REDIRECT_BUBBLES (BUB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_req      (stall_req),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ia_pc          (ia_pc),
        .ia_en          (ia_en),
        .flush          (flush),
        .state          (state),
        .issue_count    (issue_count),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase 0 boot, 1 fetching, 2 flushing, 3 halted.
    int          m_phase;
    logic [11:0] m_pc;
    int          m_left;
    int          m_ic;
    int          m_rc;

    typedef struct {
        logic        s;
        logic        h;
        logic        r;
        logic [11:0] rp;
        logic        en;
        logic        fl;
        logic [11:0] pc;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic s, input logic h, input logic r, input logic [11:0] rp,
                                input logic en, input logic fl, input logic [11:0] pc,
                                input logic [1:0] st);
        vec_t v;
        v.s = s; v.h = h; v.r = r; v.rp = rp;
        v.en = en; v.fl = fl; v.pc = pc; v.st = st;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pc = 12'h000; m_left = 0; m_ic = 0; m_rc = 0;
    endtask

    // Present inputs just after the falling edge, settle before sampling.
    task automatic drive(input logic s, input logic h, input logic r, input logic [11:0] rp);
        @(negedge clk);
        stall_req = s; halt_req = h; redirect_valid = r; redirect_pc = rp;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic exp_en;
        exp_en = (m_phase == 1) && !stall_req && !halt_req && !redirect_valid;
        chk({tag, ".ia_en"}, 32'(ia_en), 32'(exp_en));
        chk({tag, ".flush"}, 32'(flush), 32'(m_phase == 2));
        chk({tag, ".ia_pc"}, 32'(ia_pc), 32'(m_pc));
        chk({tag, ".state"}, 32'(state), 32'(m_phase));
        chk({tag, ".issue_count"}, 32'(issue_count), PERF ? 32'(m_ic) : 32'd0);
        chk({tag, ".redirect_count"}, 32'(redirect_count), PERF ? 32'(m_rc) : 32'd0);
    endtask

    // Clock edge: model consumes the inputs held through this cycle.
    task automatic advance();
        logic exp_en;
        exp_en = (m_phase == 1) && !stall_req && !halt_req && !redirect_valid;
        @(posedge clk);
        if (exp_en && m_ic < 16'hFFFF) m_ic++;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_left = BUB; m_phase = 2;
            if (m_rc < 16'hFFFF) m_rc++;
        end else if (m_phase == 1) begin
            if (halt_req) m_phase = 3;
            else if (!stall_req) m_pc = m_pc + 12'd1;
        end else if (m_phase == 2) begin
            m_left--;
            if (m_left == 0) m_phase = 1;
        end
    endtask

    // Reset asserted between edges; released just after a rising edge so the
    // next sampled cycle is the BOOT cycle.
    task automatic apply_reset_now();
        stall_req = 0; halt_req = 0; redirect_valid = 0; redirect_pc = '0;
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic s, input logic h, input logic r, input logic [11:0] rp,
                        input string tag);
        drive(s, h, r, rp);
        check_model(tag);
        advance();
    endtask

    initial begin
        int ic0;
        rst = 1'b0;
        stall_req = 0; halt_req = 0; redirect_valid = 0; redirect_pc = '0;
        model_reset();

        // Directed table: boot, sequential fetch, stall, redirects, halt.
        tbl.push_back(mk(0,0,0,12'h000, 0,0,12'h000,2'd0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,12'h000, 1,0,12'(i),2'd1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,12'h000, 0,0,12'h005,2'd1));
        for (int i = 5; i < 16; i++) tbl.push_back(mk(0,0,0,12'h000, 1,0,12'(i),2'd1));
        tbl.push_back(mk(0,0,1,12'h100, 0,0,12'h010,2'd1));
        tbl.push_back(mk(0,0,0,12'h000, 0,1,12'h100,2'd2));
        tbl.push_back(mk(0,0,0,12'h000, 0,1,12'h100,2'd2));
        tbl.push_back(mk(0,0,0,12'h000, 1,0,12'h100,2'd1));
        tbl.push_back(mk(0,0,0,12'h000, 1,0,12'h101,2'd1));
        tbl.push_back(mk(0,0,1,12'h180, 0,0,12'h102,2'd1));
        tbl.push_back(mk(0,0,1,12'h200, 0,1,12'h180,2'd2));
        tbl.push_back(mk(0,0,0,12'h000, 0,1,12'h200,2'd2));
        tbl.push_back(mk(0,0,0,12'h000, 0,1,12'h200,2'd2));
        tbl.push_back(mk(0,0,0,12'h000, 1,0,12'h200,2'd1));
        tbl.push_back(mk(0,1,0,12'h000, 0,0,12'h201,2'd1));
        tbl.push_back(mk(1,0,0,12'h000, 0,0,12'h201,2'd3));
        tbl.push_back(mk(0,0,0,12'h000, 0,0,12'h201,2'd3));
        tbl.push_back(mk(1,0,0,12'h000, 0,0,12'h201,2'd3));
        tbl.push_back(mk(1,0,1,12'h040, 0,0,12'h201,2'd3));
        tbl.push_back(mk(1,1,0,12'h000, 0,1,12'h040,2'd2));
        tbl.push_back(mk(0,0,0,12'h000, 0,1,12'h040,2'd2));
        tbl.push_back(mk(0,0,0,12'h000, 1,0,12'h040,2'd1));

        #2 rst = 1'b1;
        #1;
        chk("reset.state", 32'(state), 32'd0);
        chk("reset.ia_pc", 32'(ia_pc), 32'h000);
        chk("reset.ia_en", 32'(ia_en), 32'd0);
        chk("reset.flush", 32'(flush), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].h, tbl[i].r, tbl[i].rp);
            chk($sformatf("vec%0d.ia_en", i), 32'(ia_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d.flush", i), 32'(flush), 32'(tbl[i].fl));
            chk($sformatf("vec%0d.ia_pc", i), 32'(ia_pc), 32'(tbl[i].pc));
            chk($sformatf("vec%0d.state", i), 32'(state), 32'(tbl[i].st));
            check_model($sformatf("vec%0d.model", i));
            advance();
        end
        drive(0, 0, 0, 12'h000);
        chk("table.issue_count", 32'(issue_count), PERF ? 32'd20 : 32'd0);
        chk("table.redirect_count", 32'(redirect_count), PERF ? 32'd4 : 32'd0);
        advance();

        // PC wrap: redirect to FFE, then three issues FFE, FFF, 000.
        step(0, 0, 1, 12'hFFE, "wrap.redir");
        step(0, 0, 0, 12'h000, "wrap.fl1");
        step(0, 0, 0, 12'h000, "wrap.fl2");
        drive(0, 0, 0, 12'h000);
        ic0 = int'(issue_count);
        chk("wrap.pc0", 32'(ia_pc), 32'hFFE);
        advance();
        drive(0, 0, 0, 12'h000);
        chk("wrap.pc1", 32'(ia_pc), 32'hFFF);
        advance();
        drive(0, 0, 0, 12'h000);
        chk("wrap.pc2", 32'(ia_pc), 32'h000);
        chk("wrap.en2", 32'(ia_en), 32'd1);
        advance();
        drive(0, 0, 0, 12'h000);
        chk("wrap.issue_delta", 32'(int'(issue_count) - ic0), PERF ? 32'd3 : 32'd0);
        check_model("wrap.after");
        advance();

        // Reset in the middle of a flush discards the pending redirect.
        step(0, 0, 1, 12'h300, "rstmid.redir");
        drive(0, 0, 0, 12'h000);
        chk("rstmid.flush_before", 32'(flush), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.state", 32'(state), 32'd0);
        chk("rstmid.ia_pc", 32'(ia_pc), 32'h000);
        chk("rstmid.flush", 32'(flush), 32'd0);
        chk("rstmid.ia_en", 32'(ia_en), 32'd0);
        chk("rstmid.redirect_count", 32'(redirect_count), 32'd0);
        apply_reset_now();
        step(0, 0, 0, 12'h000, "rstmid.boot");
        step(0, 0, 0, 12'h000, "rstmid.run");

        // Randomized traffic against the model, with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            logic s, h, r;
            logic [11:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = 12'($urandom);
            if (i == 200) begin
                @(negedge clk);
                #3;
                apply_reset_now();
            end
            step(s, h, r, rp, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_sequencer
